// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one- or two-word instructions from a 16-bit
// memory port and presents them to the decoder, with redirect and drain support.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_load_addr,
  output logic [15:0] instruction,
  output logic [15:0] immediate,
  output logic        ext_word,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ack
);

  typedef enum logic [2:0] {
    FETCH_OP,
    WAIT_OP,
    FETCH_IMM,
    WAIT_IMM,
    PRESENT,
    DRAIN
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] op_q, op_nxt;
  logic [15:0] imm_q, imm_nxt;
  logic [15:0] ipc_q, ipc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_OP;
      pc    <= 16'h0000;
      op_q  <= 16'h0000;
      imm_q <= 16'h0000;
      ipc_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      op_q  <= op_nxt;
      imm_q <= imm_nxt;
      ipc_q <= ipc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    op_nxt    = op_q;
    imm_nxt   = imm_q;
    ipc_nxt   = ipc_q;
    if (pc_load) begin
      // A redirect with a read still in flight must swallow that response first.
      pc_nxt = {pc_load_addr[15:1], 1'b0};
      case (state)
        WAIT_OP, WAIT_IMM, DRAIN: state_nxt = mem_ready ? FETCH_OP : DRAIN;
        default:                  state_nxt = FETCH_OP;
      endcase
    end else begin
      case (state)
        FETCH_OP:  state_nxt = WAIT_OP;
        WAIT_OP: begin
          if (mem_ready) begin
            op_nxt    = mem_rdata;
            ipc_nxt   = pc;
            imm_nxt   = 16'h0000;
            pc_nxt    = pc + 16'd2;
            state_nxt = mem_rdata[15] ? FETCH_IMM : PRESENT;
          end
        end
        FETCH_IMM: state_nxt = WAIT_IMM;
        WAIT_IMM: begin
          if (mem_ready) begin
            imm_nxt   = mem_rdata;
            pc_nxt    = pc + 16'd2;
            state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (instr_ack) state_nxt = FETCH_OP;
        end
        DRAIN: begin
          if (mem_ready) state_nxt = FETCH_OP;
        end
        default:   state_nxt = FETCH_OP;
      endcase
    end
  end

  // Decoder handshake: a transfer happens in a cycle where instr_valid and
  // instr_ack are both 1; payload is held stable while instr_valid=1 and
  // instr_ack is ignored otherwise. Outputs are forced to zero while rst=1.
  assign mem_rd      = ~rst & ~pc_load & ((state == FETCH_OP) || (state == FETCH_IMM));
  assign mem_addr    = rst ? 16'h0000 : pc;
  assign instr_valid = ~rst & (state == PRESENT);
  assign instruction = rst ? 16'h0000 : op_q;
  assign immediate   = rst ? 16'h0000 : imm_q;
  assign ext_word    = ~rst & op_q[15];
  assign instr_pc    = rst ? 16'h0000 : ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with programmable latency,
// scoreboard of expected fetch addresses and presented instructions.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic        ext_word;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_rd_q[$];
  logic [48:0] exp_instr_q[$];

  bit [15:0] mem [0:32767];
  int        lat  = 1;
  int        cnt  = 0;
  logic      pend = 1'b0;
  logic [15:0] paddr = 16'h0000;
  logic      prev_valid = 1'b0;

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .instruction  (instruction),
    .immediate    (immediate),
    .ext_word     (ext_word),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ack    (instr_ack)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model: one response, lat cycles after the request is seen
  always @(negedge clk) begin
    mem_ready <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[paddr[15:1]];
        pend      <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (mem_rd) begin
      pend  <= 1'b1;
      cnt   <= lat;
      paddr <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      chk("rd_expected", (exp_rd_q.size() > 0), 1);
      if (exp_rd_q.size() > 0) chk("rd_addr", mem_addr, exp_rd_q.pop_front());
    end
    if (instr_valid === 1'b1 && !prev_valid) begin
      chk("instr_expected", (exp_instr_q.size() > 0), 1);
      if (exp_instr_q.size() > 0)
        chk("instr_payload", {instruction, immediate, ext_word, instr_pc}, exp_instr_q.pop_front());
    end
    prev_valid <= (instr_valid === 1'b1);
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [15:0] op, input logic [15:0] imm, input logic [15:0] pc);
    exp_instr_q.push_back({op, imm, op[15], pc});
  endtask

  task automatic wait_valid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  task automatic ack_pulse();
    cyc();
    instr_ack = 1'b1;
    cyc();
    instr_ack = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instruction"}, instruction, 16'h0000);
    chk({tag, "_immediate"}, immediate, 16'h0000);
    chk({tag, "_ext_word"}, ext_word, 0);
    chk({tag, "_instr_pc"}, instr_pc, 16'h0000);
  endtask

  initial begin
    logic found;
    rst = 1'b1; pc_load = 1'b0; pc_load_addr = 16'h0000; instr_ack = 1'b0;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    mem[16'h0000 >> 1] = 16'h2001;
    mem[16'h0010 >> 1] = 16'h8103;
    mem[16'h0012 >> 1] = 16'hBEEF;
    mem[16'h0014 >> 1] = 16'h1234;
    mem[16'h0018 >> 1] = 16'h0055;
    mem[16'h0020 >> 1] = 16'h9001;
    mem[16'h0022 >> 1] = 16'hCAFE;
    mem[16'h0040 >> 1] = 16'h0777;
    mem[16'hFFFE >> 1] = 16'h0123;
    repeat (3) cyc();
    @(negedge clk);
    chk_reset_outs("reset");

    // reset release, first fetch at 0x0000, then steady 3-cycle throughput
    exp_rd_q.push_back(16'h0000);
    push_instr(16'h2001, 16'h0000, 16'h0000);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("first_rd", mem_rd, 1);
    chk("first_addr", mem_addr, 16'h0000);
    wait_valid("valid_0000");
    for (int a = 2; a <= 6; a += 2) begin
      exp_rd_q.push_back(16'(a));
      push_instr(16'h0000, 16'h0000, 16'(a));
    end
    cyc();
    instr_ack = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      @(negedge clk);
      chk("thru_rd", mem_rd, (i % 3 == 1));
    end
    cyc();
    cyc();
    instr_ack = 1'b0;

    // two-word instruction at 0x0010
    exp_rd_q.push_back(16'h0010);
    exp_rd_q.push_back(16'h0012);
    push_instr(16'h8103, 16'hBEEF, 16'h0010);
    cyc();
    pc_load = 1'b1; pc_load_addr = 16'h0010;
    cyc();
    pc_load = 1'b0;
    @(negedge clk);
    chk("load_valid_drop", instr_valid, 0);
    wait_valid("valid_0010");
    exp_rd_q.push_back(16'h0014);
    push_instr(16'h1234, 16'h0000, 16'h0014);
    ack_pulse();
    @(negedge clk);
    chk("rd_after_ext", mem_rd, 1);
    chk("rd_after_ext_addr", mem_addr, 16'h0014);
    wait_valid("valid_0014");

    // decoder stall: payload held, no fetch
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("hold_valid", instr_valid, 1);
      chk("hold_payload", {instruction, immediate, ext_word, instr_pc}, {16'h1234, 16'h0000, 1'b0, 16'h0014});
      chk("hold_no_rd", mem_rd, 0);
    end
    exp_rd_q.push_back(16'h0016);
    push_instr(16'h0000, 16'h0000, 16'h0016);
    ack_pulse();
    @(negedge clk);
    chk("resume_rd", mem_rd, 1);
    wait_valid("valid_0016");

    // redirect with a slow read outstanding
    lat = 4;
    exp_rd_q.push_back(16'h0018);
    exp_rd_q.push_back(16'h0040);
    push_instr(16'h0777, 16'h0000, 16'h0040);
    ack_pulse();
    cyc();
    pc_load = 1'b1; pc_load_addr = 16'h0041;
    cyc();
    pc_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_valid", instr_valid, 0);
      chk("drain_no_rd", mem_rd, 0);
      cyc();
    end
    @(negedge clk);
    chk("drain_exit_rd", mem_rd, 1);
    chk("drain_exit_addr", mem_addr, 16'h0040);
    wait_valid("valid_0040");
    lat = 1;

    // pc_load together with instr_ack, then wrap from 0xFFFE
    exp_rd_q.push_back(16'hFFFE);
    push_instr(16'h0123, 16'h0000, 16'hFFFE);
    cyc();
    instr_ack = 1'b1; pc_load = 1'b1; pc_load_addr = 16'hFFFE;
    cyc();
    instr_ack = 1'b0; pc_load = 1'b0;
    @(negedge clk);
    chk("load_ack_valid", instr_valid, 0);
    chk("load_ack_rd", mem_rd, 1);
    chk("load_ack_addr", mem_addr, 16'hFFFE);
    wait_valid("valid_fffe");
    exp_rd_q.push_back(16'h0000);
    push_instr(16'h2001, 16'h0000, 16'h0000);
    ack_pulse();
    @(negedge clk);
    chk("wrap_rd", mem_rd, 1);
    chk("wrap_addr", mem_addr, 16'h0000);
    wait_valid("valid_wrap");

    // reset during WAIT_IMM, stray response lands after reset
    lat = 3;
    exp_rd_q.push_back(16'h0020);
    exp_rd_q.push_back(16'h0022);
    cyc();
    pc_load = 1'b1; pc_load_addr = 16'h0020;
    cyc();
    pc_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && mem_addr === 16'h0022) found = 1'b1;
    end
    chk("imm_rd_seen", found, 1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    cyc();
    exp_rd_q.push_back(16'h0000);
    push_instr(16'h2001, 16'h0000, 16'h0000);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rd", mem_rd, 1);
    chk("postrst_addr", mem_addr, 16'h0000);
    wait_valid("valid_postrst");
    lat = 1;

    // final report
    repeat (2) cyc();
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    chk("instr_queue_empty", exp_instr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
